sync_fifo_p: RTL and testbench

SYNC_FIFO_P -- requirements
Module: sync_fifo_p

---
 rtl/sync_fifo_p.sv | 104 ++++++++++
 tb/tb_sync_fifo_p.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_p.sv
// Synchronous FIFO with block-RAM storage, optional first-word-fall-through
// output, programmable almost-full/empty thresholds and sticky error flags.
module sync_fifo_p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    wr,
    input  logic                    rd,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_ready,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
    localparam logic [CW-1:0] AF_L    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr, rd_ptr, count_nxt;
    logic                  wr_acc, rd_acc, fetch;

    // A full FIFO rejects writes even when a read frees a slot the same cycle,
    // and an empty FIFO never bypasses a same-cycle write to the reader.
    assign wr_acc = wr && !full;
    assign rd_acc = rd && data_ready;

    generate
        if (FWFT != 0) begin : g_fwft
            logic          dout_vld;
            logic [CW-1:0] mem_cnt;

            // count spans RAM words plus the word parked in data_out; refill
            // the output register whenever it is empty or being consumed.
            assign mem_cnt    = wr_ptr - rd_ptr;
            assign fetch      = (mem_cnt != '0) && (!dout_vld || rd_acc);
            assign data_ready = dout_vld;

            always_ff @(posedge clk) begin
                if (reset)       dout_vld <= 1'b0;
                else if (fetch)  dout_vld <= 1'b1;
                else if (rd_acc) dout_vld <= 1'b0;
            end
        end else begin : g_std
            assign fetch      = rd_acc;
            assign data_ready = (count != '0);
        end
    endgenerate

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + 1'b1;
        else if (!wr_acc && rd_acc)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !reset)
            mem[wr_ptr[AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            data_out <= '0;
        else if (fetch)
            data_out <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= (AF_L == '0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (fetch)  rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_L);
            almost_full  <= (count_nxt >= AF_L);
            almost_empty <= (count_nxt <= AE_L);
            // A fresh error in the clearing cycle wins over clr_err.
            overflow     <= (overflow  && !clr_err) || (wr && full);
            underflow    <= (underflow && !clr_err) || (rd && !data_ready);
        end
    end
endmodule

// File: tb/tb_sync_fifo_p.sv
// Directed bench for sync_fifo_p: three instances cover standard mode (DEPTH 8
// and 4) and first-word-fall-through mode, plus a queue-checked random stream.
module tb_sync_fifo_p;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // A: DEPTH 8, standard read, AF 6, AE 2
    logic [7:0] a_din, a_dout;
    logic       a_wr, a_rd, a_clr, a_rdy, a_full, a_af, a_ae, a_ovf, a_udf;
    logic [3:0] a_cnt;
    // B: DEPTH 4, standard read, AF 3, AE 1
    logic [7:0] b_din, b_dout;
    logic       b_wr, b_rd, b_clr, b_rdy, b_full, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_cnt;
    // C: DEPTH 8, first-word-fall-through, AF 4, AE 4
    logic [7:0] c_din, c_dout;
    logic       c_wr, c_rd, c_clr, c_rdy, c_full, c_af, c_ae, c_ovf, c_udf;
    logic [3:0] c_cnt;

    sync_fifo_p #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
        .clk(clk), .reset(reset), .data_in(a_din), .wr(a_wr), .rd(a_rd),
        .data_out(a_dout), .data_ready(a_rdy), .full(a_full), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_udf),
        .clr_err(a_clr));

    sync_fifo_p #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_b (
        .clk(clk), .reset(reset), .data_in(b_din), .wr(b_wr), .rd(b_rd),
        .data_out(b_dout), .data_ready(b_rdy), .full(b_full), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_udf),
        .clr_err(b_clr));

    sync_fifo_p #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) u_c (
        .clk(clk), .reset(reset), .data_in(c_din), .wr(c_wr), .rd(c_rd),
        .data_out(c_dout), .data_ready(c_rdy), .full(c_full), .almost_full(c_af),
        .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf), .underflow(c_udf),
        .clr_err(c_clr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] last_out;
        logic       w, r, wok, rok;
        int         nw;

        reset = 1'b1;
        {a_din, a_wr, a_rd, a_clr} = '0;
        {b_din, b_wr, b_rd, b_clr} = '0;
        {c_din, c_wr, c_rd, c_clr} = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_cnt",  a_cnt, 0);
        chk("rst_rdy",  a_rdy, 0);
        chk("rst_full", a_full, 0);
        chk("rst_af",   a_af, 0);
        chk("rst_ae",   a_ae, 1);
        chk("rst_err",  {a_ovf, a_udf}, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_c_rdy", c_rdy, 0);
        chk("rst_b_ae", b_ae, 1);

        // B: fill DEPTH 4 with five writes, fifth dropped
        b_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_din = 8'hA0 + 8'(i);
            tick();
            if (i == 2) chk("b_af3", b_af, 1);
            if (i == 3) begin
                chk("b_full4", b_full, 1);
                chk("b_cnt4", b_cnt, 4);
                chk("b_ovf_pre", b_ovf, 0);
            end
        end
        b_wr = 1'b0;
        chk("b_ovf", b_ovf, 1);
        chk("b_cnt_hold", b_cnt, 4);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("b_clr_ovf", b_ovf, 0);

        // B: full with wr+rd -> read wins, write rejected
        b_wr = 1'b1; b_rd = 1'b1; b_din = 8'hB0;
        tick();
        b_wr = 1'b0;
        chk("b_fwr_cnt", b_cnt, 3);
        chk("b_fwr_ovf", b_ovf, 1);
        chk("b_fwr_dout", b_dout, 8'hA0);
        chk("b_fwr_full", b_full, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("b_rd_dout", b_dout, 8'hA0 + 8'(i));
        end
        b_rd = 1'b0;
        chk("b_rd_cnt0", b_cnt, 0);
        chk("b_rd_rdy0", b_rdy, 0);

        // B: empty with wr+rd -> write wins, underflow
        b_wr = 1'b1; b_rd = 1'b1; b_din = 8'hC5;
        tick();
        b_wr = 1'b0;
        chk("b_ewr_cnt", b_cnt, 1);
        chk("b_ewr_udf", b_udf, 1);
        chk("b_ewr_dout", b_dout, 8'hA3);
        tick();
        chk("b_ewr_rd", b_dout, 8'hC5);
        chk("b_ewr_cnt0", b_cnt, 0);
        // clr_err with a new underflow in the same cycle keeps the flag
        b_clr = 1'b1;
        tick();
        b_rd = 1'b0;
        chk("b_clr_race", b_udf, 1);
        tick();
        b_clr = 1'b0;
        chk("b_clr_udf", b_udf, 0);

        // C: FWFT latency, write at cycle N -> valid at N+2
        c_wr = 1'b1; c_din = 8'h5A;
        tick();
        c_wr = 1'b0;
        chk("c_n1_rdy", c_rdy, 0);
        chk("c_n1_cnt", c_cnt, 1);
        tick();
        chk("c_n2_rdy", c_rdy, 1);
        chk("c_n2_dout", c_dout, 8'h5A);
        c_rd = 1'b1;
        tick();
        c_rd = 1'b0;
        chk("c_pop_cnt", c_cnt, 0);
        chk("c_pop_rdy", c_rdy, 0);

        // C: 8 queued words drained back-to-back
        c_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c_din = 8'h80 + 8'(i);
            tick();
        end
        c_wr = 1'b0;
        chk("c_q_cnt", c_cnt, 8);
        chk("c_q_full", c_full, 1);
        chk("c_q_af", c_af, 1);
        chk("c_q_rdy", c_rdy, 1);
        c_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("c_b2b_rdy", c_rdy, 1);
            chk("c_b2b_dout", c_dout, 8'h80 + 8'(i));
            tick();
        end
        c_rd = 1'b0;
        chk("c_b2b_cnt0", c_cnt, 0);
        chk("c_b2b_rdy0", c_rdy, 0);

        // A: three writes, three reads
        a_wr = 1'b1;
        a_din = 8'h11; tick();
        a_din = 8'h22; tick();
        a_din = 8'h33; tick();
        a_wr = 1'b0;
        chk("a_cnt3", a_cnt, 3);
        chk("a_ae3", a_ae, 0);
        chk("a_rdy3", a_rdy, 1);
        a_rd = 1'b1;
        tick(); chk("a_rd0", a_dout, 8'h11); chk("a_cnt2", a_cnt, 2);
        tick(); chk("a_rd1", a_dout, 8'h22); chk("a_cnt1", a_cnt, 1);
        tick(); chk("a_rd2", a_dout, 8'h33); chk("a_cnt0", a_cnt, 0);
        a_rd = 1'b0;
        chk("a_rdy0", a_rdy, 0);
        tick();
        chk("a_hold", a_dout, 8'h33);

        // A: reset mid-operation with count 5
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        chk("a_udf", a_udf, 1);
        a_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_din = 8'h40 + 8'(i);
            tick();
        end
        a_wr = 1'b0;
        chk("a_cnt5", a_cnt, 5);
        reset = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_clr = 1'b0; a_din = 8'hEE;
        tick();
        reset = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
        chk("a_mrst_cnt", a_cnt, 0);
        chk("a_mrst_rdy", a_rdy, 0);
        chk("a_mrst_flags", {a_ovf, a_udf, a_full, a_af}, 0);
        chk("a_mrst_ae", a_ae, 1);
        chk("a_mrst_dout", a_dout, 0);
        a_wr = 1'b1; a_din = 8'h77;
        tick();
        a_wr = 1'b0; a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        chk("a_new_dout", a_dout, 8'h77);
        chk("a_new_cnt", a_cnt, 0);

        // A: 100-word random stream checked against a reference queue
        last_out = 8'h77;
        nw = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            w = (nw < 100) && ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            a_wr = w; a_rd = r; a_din = 8'hC3 ^ 8'(nw);
            wok = w && (q.size() < 8);
            rok = r && (q.size() > 0);
            tick();
            if (rok) last_out = q.pop_front();
            if (wok) begin
                q.push_back(a_din);
                nw++;
            end
            chk("rnd_dout", a_dout, last_out);
            chk("rnd_cnt",  a_cnt, q.size());
            chk("rnd_af",   a_af, q.size() >= 6);
            chk("rnd_ae",   a_ae, q.size() <= 2);
            chk("rnd_full", a_full, q.size() == 8);
            if (nw == 100 && q.size() == 0) break;
        end
        a_wr = 1'b0; a_rd = 1'b0;
        chk("rnd_words", nw, 100);
        chk("rnd_drain", a_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
